// File: rtl/nw_ctrl_fsm_p_if.sv
// nw_ctrl_fsm_p_if -- handshake/control bundle for the Needleman-Wunsch
// matrix-fill controller.
//   master : drives start/abort and the datapath status strobes
//            (init_done, calc, tb_done); observes enables, cell and state.
//   slave  : the controller; consumes the strobes, drives the enables,
//            busy/done, current cell (row, col) and the raw state code.
// IW/JW must match the controller's row/column index widths.
interface nw_ctrl_fsm_p_if #(
  parameter int IW = 4,
  parameter int JW = 4
);
  logic          start;
  logic          abort;
  logic          init_done;
  logic          calc;
  logic          tb_done;
  logic          en_init;
  logic          en_ins;
  logic          we;
  logic          en_read;
  logic          en_traceB;
  logic          busy;
  logic          done;
  logic [IW-1:0] row;
  logic [JW-1:0] col;
  logic [2:0]    state;

  modport master (
    output start, abort, init_done, calc, tb_done,
    input  en_init, en_ins, we, en_read, en_traceB, busy, done, row, col, state
  );

  modport slave (
    input  start, abort, init_done, calc, tb_done,
    output en_init, en_ins, we, en_read, en_traceB, busy, done, row, col, state
  );
endinterface

// File: rtl/nw_ctrl_fsm_p.sv
// nw_ctrl_fsm_p -- sequencing FSM for a Needleman-Wunsch alignment datapath.
// Walks an N x M score matrix one cell at a time: INIT until the datapath
// reports init_done, then a READ/FILL pair per cell (READ waits on calc,
// FILL writes for one cycle), then TRACEB until tb_done, then a one-cycle
// END with done=1. abort returns to IDLE from any busy state.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset (forces IDLE, cell (1,1))
//   bus  : nw_ctrl_fsm_p_if.slave -- start/abort/init_done/calc/tb_done in;
//          en_init/en_ins/we/en_read/en_traceB/busy/done/row/col/state out.
//
// Build option: define NW_BAND_EN to visit only cells with |i-j| <= BAND
// (row-major order inside the diagonal band). Without it BAND is unused and
// every cell is visited.
module nw_ctrl_fsm_p #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int IW   = 4,
  parameter int JW   = 4,
  parameter int BAND = 2
) (
  input  logic           clk,
  input  logic           rst,
  nw_ctrl_fsm_p_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if ((1 << IW) <= N) begin : g_iw_chk
    $error("nw_ctrl_fsm_p: IW too narrow for N");
  end
  if ((1 << JW) <= M) begin : g_jw_chk
    $error("nw_ctrl_fsm_p: JW too narrow for M");
  end
`ifdef NW_BAND_EN
  if ((N - M > BAND) || (M - N > BAND)) begin : g_band_chk
    $error("nw_ctrl_fsm_p: (N,M) lies outside the band");
  end
`else
  if (BAND < 0) begin : g_band_chk
    $error("nw_ctrl_fsm_p: BAND must be non-negative");
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_READ   = 3'd2,
    S_FILL   = 3'd3,
    S_TRACEB = 3'd4,
    S_END    = 3'd5
  } state_t;

  localparam logic [IW-1:0] ROW_ONE  = IW'(1);
  localparam logic [IW-1:0] ROW_LAST = IW'(N);
  localparam logic [JW-1:0] COL_ONE  = JW'(1);
  localparam logic [JW-1:0] COL_LAST = JW'(M);

  state_t        state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [JW-1:0] col_q, col_d;

  // Cell-advance helpers: row_end marks the last visited column of the
  // current row, col_first the first visited column of the next row.
  logic          at_last;
  logic          row_end;
  logic [JW-1:0] col_first;

  assign at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef NW_BAND_EN
  logic [31:0]   band_hi;
  logic [JW-1:0] band_lo;

  always_comb begin
    // min(M, i+BAND)
    band_hi = 32'(row_q) + 32'(BAND);
    if (band_hi > 32'(M)) band_hi = 32'(M);
    // max(1, (i+1)-BAND): first in-band column of the following row
    band_lo = COL_ONE;
    if (32'(row_q) >= 32'(BAND)) band_lo = JW'(32'(row_q) + 32'd1 - 32'(BAND));
  end

  assign row_end   = (32'(col_q) == band_hi);
  assign col_first = band_lo;
`else
  assign row_end   = (col_q == COL_LAST);
  assign col_first = COL_ONE;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= ROW_ONE;
      col_q   <= COL_ONE;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state and cell-index logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          row_d   = ROW_ONE;
          col_d   = COL_ONE;
        end
      end
      S_INIT:   if (bus.init_done) state_d = S_READ;
      S_READ:   if (bus.calc)      state_d = S_FILL;
      S_FILL: begin
        if (at_last) begin
          state_d = S_TRACEB;          // row/col stay at (N,M) for traceback
        end else begin
          state_d = S_READ;
          if (row_end) begin
            row_d = row_q + ROW_ONE;
            col_d = col_first;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      S_TRACEB: if (bus.tb_done) state_d = S_END;
      // END (and the unused codes 6/7) fall back to IDLE unconditionally;
      // the cell is re-homed so IDLE always shows (1,1).
      default: begin
        state_d = S_IDLE;
        row_d   = ROW_ONE;
        col_d   = COL_ONE;
      end
    endcase
    // abort overrides everything else once a run is in progress
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      row_d   = ROW_ONE;
      col_d   = COL_ONE;
    end
  end

  // Moore output decode
  always_comb begin
    bus.en_init   = 1'b0;
    bus.en_ins    = 1'b0;
    bus.we        = 1'b0;
    bus.en_read   = 1'b0;
    bus.en_traceB = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    case (state_q)
      S_INIT: begin
        bus.en_init = 1'b1;
        bus.we      = 1'b1;
      end
      S_READ: begin
        bus.en_ins  = 1'b1;
        bus.en_read = 1'b1;
      end
      S_FILL:   bus.we        = 1'b1;
      S_TRACEB: bus.en_traceB = 1'b1;
      S_END:    bus.done      = 1'b1;
      default: ;
    endcase
  end

  assign bus.row   = row_q;
  assign bus.col   = col_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_nw_ctrl_fsm_p.sv
// tb_nw_ctrl_fsm_p -- scoreboard bench for nw_ctrl_fsm_p.
// Stimulus pushes the expected FILL cells and done times into queues; the
// monitor pops on every FILL cycle and every done pulse. Directed checks
// cover reset, stall, abort and asynchronous reset.
module tb_nw_ctrl_fsm_p;
  localparam int IW = 4;
  localparam int JW = 4;
`ifdef NW_BAND_EN
  localparam int TN = 4;
  localparam int TM = 4;
  localparam int TB = 1;
`else
  localparam int TN = 3;
  localparam int TM = 3;
  localparam int TB = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nw_ctrl_fsm_p_if #(.IW(IW), .JW(JW)) bus ();

  nw_ctrl_fsm_p #(.N(TN), .M(TM), .IW(IW), .JW(JW), .BAND(TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  int cells[$];    // visit order, encoded row*10+col
  int cell_q[$];   // expected FILL cells
  int lat_q[$];    // expected edge count at the done cycle

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {en_init,en_ins,we,en_read,en_traceB,busy,done} per state code
  function automatic logic [6:0] exp_dec(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b0000000;
      3'd1:    return 7'b1010010;
      3'd2:    return 7'b0101010;
      3'd3:    return 7'b0010010;
      3'd4:    return 7'b0000110;
      3'd5:    return 7'b0000011;
      default: return 7'b0000010;
    endcase
  endfunction

  function automatic int cur_cell();
    return int'(bus.row) * 10 + int'(bus.col);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("decode", int'({bus.en_init, bus.en_ins, bus.we, bus.en_read,
                          bus.en_traceB, bus.busy, bus.done}), int'(exp_dec(bus.state)));
      if (bus.state == 3'd3) begin
        if (cell_q.size() == 0) chk("unexpected_fill", cur_cell(), 0);
        else chk("fill_cell", cur_cell(), cell_q.pop_front());
      end
      if (bus.state == 3'd4) chk("traceb_cell", cur_cell(), TN * 10 + TM);
      if (bus.done) begin
        if (lat_q.size() == 0) chk("unexpected_done", ecnt, 0);
        else chk("done_time", ecnt, lat_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until state==s (and cell==rc unless rc==0), bounded.
  task automatic wait_cell(input int s, input int rc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.state == 3'(s) && (rc == 0 || cur_cell() == rc)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_s%0d_c%0d: timed out, got state %0d want %0d", s, rc, bus.state, s);
    end
  endtask

  // Queue expected cells up to (not including) stop; stop==0 queues all.
  task automatic push_cells(input int stop);
    foreach (cells[i]) begin
      if (cells[i] == stop) break;
      cell_q.push_back(cells[i]);
    end
  endtask

  task automatic go(output int t0);
    bus.start = 1'b1;
    tick();
    t0 = ecnt;
    chk("start_to_init", int'(bus.state), 1);
  endtask

  initial begin
    int t0;
`ifdef NW_BAND_EN
    cells = '{11, 12, 21, 22, 23, 32, 33, 34, 43, 44};
`else
    cells = '{11, 12, 13, 21, 22, 23, 31, 32, 33};
`endif
    bus.start = 0; bus.abort = 0; bus.init_done = 0; bus.calc = 0; bus.tb_done = 0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b0;
    #2;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_cell", cur_cell(), 11);
    chk("rst_busy_done_we", int'({bus.busy, bus.done, bus.we}), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("idle_after_release", int'(bus.state), 0);
    bus.init_done = 1; bus.calc = 1; bus.tb_done = 1;
    tick();
    chk("idle_ignores_strobes", int'(bus.state), 0);

    // Run 1: all handshakes high; start held through READ and END
    push_cells(0);
    go(t0);
    lat_q.push_back(t0 + 2 * cells.size() + 2);
    wait_cell(5, 0);
    tick();
    chk("end_ignores_start", int'(bus.state), 0);
    chk("end_rehome_cell", cur_cell(), 11);
    bus.start = 0;
    tick();
    chk("idle_stays", int'(bus.state), 0);

    // Run 2: calc held low for 5 READ cycles at (2,2)
    push_cells(0);
    go(t0);
    bus.start = 0;
    lat_q.push_back(t0 + 2 * cells.size() + 2 + 5);
    wait_cell(3, 21);
    bus.calc = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_state", int'(bus.state), 2);
      chk("stall_rd_we", int'({bus.en_read, bus.we}), 2);
      chk("stall_cell", cur_cell(), 22);
      tick();
    end
    bus.calc = 1;
    tick();
    chk("stall_release_fill", int'(bus.state), 3);
    chk("stall_release_cell", cur_cell(), 22);
    wait_cell(0, 0);

    // Run 3: abort together with calc in READ of (1,2)
    push_cells(12);
    go(t0);
    bus.start = 0;
    wait_cell(2, 12);
    bus.abort = 1;
    tick();
    chk("abort_state", int'(bus.state), 0);
    chk("abort_cell", cur_cell(), 11);
    chk("abort_busy", int'(bus.busy), 0);
    bus.abort = 0;
    tick();
    chk("abort_idle_holds", int'(bus.state), 0);

    // Run 4: asynchronous reset in the middle of FILL (2,1)
    push_cells(21);
    go(t0);
    bus.start = 0;
    wait_cell(3, 21);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", int'(bus.state), 0);
    chk("async_rst_we", int'(bus.we), 0);
    chk("async_rst_cell", cur_cell(), 11);
    chk("async_rst_busy", int'(bus.busy), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", int'(bus.state), 0);

    // Run 5: clean run after reset
    push_cells(0);
    go(t0);
    bus.start = 0;
    lat_q.push_back(t0 + 2 * cells.size() + 2);
    wait_cell(0, 0);
    repeat (3) tick();

    chk("cells_left", cell_q.size(), 0);
    chk("dones_left", lat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nw_ctrl_fsm_p.md
NW_CTRL_FSM_P -- requirements
Module: nw_ctrl_fsm_p

Interface
REQ-001 SHALL have parameter N, default 8: rows (sequence A length), N >= 1.
REQ-002 SHALL have parameter M, default 8: columns (sequence B length), M >= 1.
REQ-003 SHALL have parameter IW, default 4: row index width; 2^IW > N.
REQ-004 SHALL have parameter JW, default 4: column index width; 2^JW > M.
REQ-005 SHALL have parameter BAND, default 2: diagonal half-width, used only when banding is compiled in; |N-M| <= BAND required.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: begin alignment; sampled only in IDLE.
REQ-009 SHALL have port abort, input, 1: synchronous return to IDLE.
REQ-010 SHALL have ports init_done, calc and tb_done, input, 1 each: matrix init finished, cell score ready, traceback finished.
REQ-011 SHALL have ports en_init, en_ins, we, en_read and en_traceB, output, 1 each: datapath enables.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: high for exactly the one cycle spent in END.
REQ-014 SHALL have ports row, output, IW and col, output, JW: current cell (i,j), 1-based.
REQ-015 SHALL have port state, output, 3: IDLE=0, INIT=1, READ=2, FILL=3, TRACEB=4, END=5.

Function
REQ-016 Outputs SHALL be Moore decodes of the registered state; codes 6-7 SHALL decode as all enables 0 and SHALL go to IDLE next cycle.
REQ-017 IDLE: all enables 0; start=1 -> INIT next cycle, row=1, col=1.
REQ-018 INIT: en_init=1, we=1; init_done=1 -> READ next cycle, else stay.
REQ-019 READ: en_ins=1, en_read=1, we=0; calc=1 -> FILL next cycle, else stay indefinitely.
REQ-020 FILL: we=1 for exactly one cycle; at (N,M) -> TRACEB, else -> READ with the cell advanced.
REQ-021 Advance (unbanded) SHALL be row-major: col<M -> col+1; col=M -> row+1, col=1.
REQ-022 TRACEB: en_traceB=1; tb_done=1 -> END; row/col SHALL hold (N,M).
REQ-023 END: done=1 for one cycle, then IDLE unconditionally; start in END SHALL be ignored.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle, row=1, col=1; abort SHALL win over every simultaneous input.
REQ-025 Inputs irrelevant to the current state (e.g. calc in INIT, start while busy) SHALL be ignored.
REQ-026 Cell count (unbanded) SHALL be N*M FILL cycles; minimum latency start -> done SHALL be 1 + 1 + 2*N*M + 1 + 1 cycles with all handshakes high.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, row=1, col=1, all enables, busy and done 0, independent of clk.
REQ-028 Reset release SHALL take effect only on a later clk edge; reset mid-fill SHALL discard progress.

Configuration
REQ-029 With macro NW_BAND_EN defined, only cells with |i-j| <= BAND SHALL be visited: col=min(M,i+BAND) -> row+1, col=max(1,row+1-BAND); out-of-band cells SHALL get no READ/FILL cycles.
REQ-030 Without NW_BAND_EN, BAND SHALL be ignored and all N*M cells SHALL be visited.

Verification
REQ-031 N=M=2, start, init_done/calc/tb_done held 1 -> state 0,1,2,3,2,3,2,3,2,3,4,5,0; cells (1,1),(1,2),(2,1),(2,2); done 1 cycle; 12 cycles.
REQ-032 N=M=3, calc held low 5 cycles in READ of (2,2) -> en_read stays 1, we stays 0, no advance; FILL follows one cycle after calc rises.
REQ-033 abort and calc both 1 in READ of (1,2) -> IDLE next cycle, row=1, col=1, busy=0, no FILL.
REQ-034 rst=0 asserted mid-FILL between edges -> state=0 and we=0 before the next clk edge.
REQ-035 NW_BAND_EN, N=M=4, BAND=1 -> cells visited (1,1),(1,2),(2,1),(2,2),(2,3),(3,2),(3,3),(3,4),(4,3),(4,4); 10 FILL cycles.
REQ-036 start=1 in END and in READ -> ignored; new run begins only from IDLE.
